// File: rtl/adc_ctrl_pkg.sv
// Shared types and defaults for the AD574-style ADC sequencer.
// The pin-drive helper keeps the CS/CE/RC encoding for each state in one place.
package adc_ctrl_pkg;

    localparam int ADC_W = 12;
    localparam int CH_W  = 4;
    localparam int CNT_W = 16;

    localparam int SETTLE_CYCLES_DEF    = 8;
    localparam int START_CYCLES_DEF     = 4;
    localparam int BUSY_WAIT_CYCLES_DEF = 16;
    localparam int READ_CYCLES_DEF      = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        READ,
        DONE
    } state_t;

    typedef struct packed {
        logic csn;
        logic ce;
        logic rc;
    } pins_t;

    // START is a convert strobe (RC=0), READ a read strobe (RC=1); otherwise the ADC is deselected.
    function automatic pins_t pins_for(input state_t s);
        pins_t p;
        p = '{csn: 1'b1, ce: 1'b0, rc: 1'b1};
        if (s == START) p = '{csn: 1'b0, ce: 1'b1, rc: 1'b0};
        if (s == READ)  p = '{csn: 1'b0, ce: 1'b1, rc: 1'b1};
        return p;
    endfunction

endpackage

// File: rtl/adc_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous status inputs.
module adc_ctrl_sync2 #(
    parameter int W = 1
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_ctrl.sv
// Sequencer for a 12-bit parallel ADC behind a 16:1 mux: select, settle, convert, wait on STS, read.
// Pin outputs are registered from the next state so each strobe lines up exactly with its state.
module adc_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES    = SETTLE_CYCLES_DEF,
    parameter int START_CYCLES     = START_CYCLES_DEF,
    parameter int BUSY_WAIT_CYCLES = BUSY_WAIT_CYCLES_DEF,
    parameter int READ_CYCLES      = READ_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Read,
    input  logic [CH_W-1:0]  Channel_Select,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_STS,
    output logic [CH_W-1:0]  ADC_MUX,
    output logic             ADC_CSn,
    output logic             ADC_CE,
    output logic             ADC_RC,
    output logic [ADC_W-1:0] Data,
    output logic [CH_W-1:0]  Data_Channel,
    output logic             Data_Valid,
    output logic             Busy
);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CH_W-1:0]  ch_reg;
    logic             sts_s;
    pins_t            pins;

    adc_ctrl_sync2 #(.W(1)) u_sts_sync (
        .gclk   (CLK),
        .grst_n (RSTn),
        .d      (ADC_STS),
        .q      (sts_s)
    );

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt + 1'b1;
        case (state)
            IDLE:      if (Read) nxt = SETTLE;
            SETTLE:    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) nxt = START;
            START:     if (cnt == CNT_W'(START_CYCLES - 1)) nxt = WAIT_BUSY;
            // A missed or already-finished conversion falls through after the timeout.
            WAIT_BUSY: if (sts_s || cnt == CNT_W'(BUSY_WAIT_CYCLES - 1)) nxt = WAIT_DONE;
            WAIT_DONE: if (!sts_s) nxt = READ;
            READ:      if (cnt == CNT_W'(READ_CYCLES - 1)) nxt = DONE;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        if (nxt != state || state == IDLE || state == WAIT_DONE) cnt_nxt = '0;
        pins = pins_for(nxt);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state        <= IDLE;
            cnt          <= '0;
            ch_reg       <= '0;
            ADC_CSn      <= 1'b1;
            ADC_CE       <= 1'b0;
            ADC_RC       <= 1'b1;
            Data         <= '0;
            Data_Channel <= '0;
            Data_Valid   <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            ADC_CSn    <= pins.csn;
            ADC_CE     <= pins.ce;
            ADC_RC     <= pins.rc;
            Busy       <= (nxt != IDLE);
            Data_Valid <= (nxt == DONE);
            if (state == IDLE && Read) ch_reg <= Channel_Select;
            // Sample the bus on the last read-strobe cycle, when its output is stable.
            if (state == READ && nxt == DONE) begin
                Data         <= ADC_DATA;
                Data_Channel <= ch_reg;
            end
        end
    end

    assign ADC_MUX = ch_reg;

endmodule

// File: tb/tb_adc_ctrl.sv
// Directed + randomized bench for adc_ctrl; expected timing is derived from the sequencing
// rules (settle/start/timeout/read lengths, 2-flop STS latency) and a tiny ADC pin model.
module tb_adc_ctrl;

    localparam int SET = 8;
    localparam int STC = 4;
    localparam int BWC = 16;
    localparam int RDC = 4;
    localparam int LIM = 400;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        Read = 1'b0;
    logic [3:0]  Channel_Select = '0;
    logic [11:0] ADC_DATA = '0;
    logic        ADC_STS = 1'b0;
    logic [3:0]  ADC_MUX;
    logic        ADC_CSn, ADC_CE, ADC_RC;
    logic [11:0] Data;
    logic [3:0]  Data_Channel;
    logic        Data_Valid, Busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    adc_ctrl #(
        .SETTLE_CYCLES(SET), .START_CYCLES(STC),
        .BUSY_WAIT_CYCLES(BWC), .READ_CYCLES(RDC)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Read(Read), .Channel_Select(Channel_Select),
        .ADC_DATA(ADC_DATA), .ADC_STS(ADC_STS), .ADC_MUX(ADC_MUX),
        .ADC_CSn(ADC_CSn), .ADC_CE(ADC_CE), .ADC_RC(ADC_RC), .Data(Data),
        .Data_Channel(Data_Channel), .Data_Valid(Data_Valid), .Busy(Busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    // Number of consecutive sampled cycles with CSn at lvl, starting with the current one.
    task automatic count_while(input logic lvl, output int n);
        n = 0;
        while (ADC_CSn === lvl && n < LIM) begin
            n++;
            tick;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mux"},  32'(ADC_MUX), 0);
        chk({tag, "_csn"},  32'(ADC_CSn), 1);
        chk({tag, "_ce"},   32'(ADC_CE), 0);
        chk({tag, "_rc"},   32'(ADC_RC), 1);
        chk({tag, "_data"}, 32'(Data), 0);
        chk({tag, "_dch"},  32'(Data_Channel), 0);
        chk({tag, "_dv"},   32'(Data_Valid), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
    endtask

    // mode 0: STS rises as the start pulse ends; 1: STS never rises (timeout); 2: STS high beforehand.
    task automatic do_conv(input logic [3:0] ch, input logic [11:0] val, input int mode,
                           input int conv, input bit drop);
        int n;
        Channel_Select = ch;
        Read = 1'b1;
        ADC_STS = (mode == 2);
        ADC_DATA = ~val;
        tick;
        chk("accept_busy", 32'(Busy), 1);
        chk("accept_mux", 32'(ADC_MUX), 32'(ch));
        chk("accept_dv", 32'(Data_Valid), 0);
        if (drop) Read = 1'b0;
        count_while(1'b1, n);
        chk("settle_len", n, SET);
        chk("start_ce", 32'(ADC_CE), 1);
        chk("start_rc", 32'(ADC_RC), 0);
        count_while(1'b0, n);
        chk("start_len", n, STC);
        Channel_Select = ch ^ 4'($urandom_range(1, 15));
        if (mode == 1) begin
            count_while(1'b1, n);
            chk("timeout_gap", n, BWC + 1);
        end else begin
            if (mode == 0) ADC_STS = 1'b1;
            repeat (conv) tick;
            chk("mux_hold", 32'(ADC_MUX), 32'(ch));
            chk("wait_csn", 32'(ADC_CSn), 1);
            ADC_STS = 1'b0;
            count_while(1'b1, n);
            chk("sts_to_read", n, 3);
        end
        chk("read_ce", 32'(ADC_CE), 1);
        chk("read_rc", 32'(ADC_RC), 1);
        n = 0;
        while (ADC_CSn === 1'b0 && n < LIM) begin
            n++;
            ADC_DATA = (n == RDC) ? val : ~val;
            tick;
        end
        chk("read_len", n, RDC);
        chk("done_dv", 32'(Data_Valid), 1);
        chk("done_data", 32'(Data), 32'(val));
        chk("done_dch", 32'(Data_Channel), 32'(ch));
        chk("done_busy", 32'(Busy), 1);
        ADC_DATA = 12'($urandom);
        tick;
        chk("idle_dv", 32'(Data_Valid), 0);
        chk("idle_busy", 32'(Busy), 0);
        chk("data_hold", 32'(Data), 32'(val));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset, with STS high as it may be at power-up.
        ADC_STS = 1'b1;
        tick;
        tick;
        chk_reset_vals("reset");
        RSTn = 1'b1;
        repeat (10) begin
            tick;
            chk("idle_csn", 32'(ADC_CSn), 1);
            chk("idle_nobusy", 32'(Busy), 0);
        end

        // Basic: channel 2, data 5, STS already high, long conversion.
        do_conv(4'd2, 12'd5, 2, 300, 1'b1);

        // Busy timeout: STS never rises.
        do_conv(4'($urandom), 12'($urandom), 1, 0, 1'b1);

        // Back-to-back with Read held high.
        for (int i = 0; i < 6; i++)
            do_conv(4'($urandom), 12'($urandom), (i == 3) ? 1 : 0,
                    (i == 0) ? 50 : int'($urandom_range(4, 40)), 1'b0);
        Read = 1'b0;
        repeat (3) begin
            tick;
            chk("rest_busy", 32'(Busy), 0);
        end

        // Reset in WAIT_DONE discards the conversion.
        Channel_Select = 4'd9;
        Read = 1'b1;
        ADC_STS = 1'b0;
        tick;
        Read = 1'b0;
        count_while(1'b1, n);
        count_while(1'b0, n);
        ADC_STS = 1'b1;
        repeat (10) tick;
        chk("pre_rst_busy", 32'(Busy), 1);
        RSTn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick;
        chk("midrst_dv", 32'(Data_Valid), 0);
        RSTn = 1'b1;
        ADC_STS = 1'b0;
        repeat (5) begin
            tick;
            chk("post_rst_busy", 32'(Busy), 0);
            chk("post_rst_dv", 32'(Data_Valid), 0);
        end
        do_conv(4'($urandom), 12'($urandom), 0, 20, 1'b1);

        // Random mix of modes and Read handling.
        for (int i = 0; i < 6; i++)
            do_conv(4'($urandom), 12'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(4, 60)), 1'($urandom));
        Read = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
